// File: rtl/bus_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : bus_cycle_controller
// Purpose  : Per-bus-cycle controller for an 8088 peripheral bus. Decodes the
//            address/IOM latched with ALE into a one-hot chip select for up
//            to four memory/IO regions. Inserts per-region wait states by
//            dropping READY. Aborts cycles that hang, hit unmapped space or
//            drive RD and WR low together.
// Ports    : CLK      in   bus clock, all state on posedge
//            RESET    in   synchronous, active-high
//            ALE      in   address latch enable, one cycle per bus cycle
//            IOM      in   1=IO cycle, 0=memory cycle, valid with ALE
//            Address  in   20-bit bus address, valid with ALE
//            RD / WR  in   read / write strobes, active low
//            CS       out  one-hot chip select, active high
//            READY    out  0 inserts a wait state
//            bus_err  out  one-cycle error pulse
//            region   out  region index of the current/last cycle
// Revision : 1.0  initial release
// ============================================================================
module bus_cycle_controller #(
    parameter logic [3:0][19:0] REG_LO   = {20'h00000, 20'h00100, 20'h80000, 20'hC0000},
    parameter logic [3:0][19:0] REG_HI   = {20'h7FFFF, 20'h001FF, 20'hBFFFF, 20'hFFFFF},
    parameter logic [3:0]       REG_IOM  = 4'b0100,
    parameter logic [3:0][2:0]  REG_WAIT = {3'd0, 3'd1, 3'd2, 3'd0},
    parameter int               TIMEOUT  = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ALE,
    input  logic        IOM,
    input  logic [19:0] Address,
    input  logic        RD,
    input  logic        WR,
    output logic [3:0]  CS,
    output logic        READY,
    output logic        bus_err,
    output logic [1:0]  region
);

    localparam int         c_TCNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_XFER = 2'd3;

    logic [1:0]          r_state;
    logic [3:0]          r_cs;
    logic [1:0]          r_region;
    logic [2:0]          r_wcnt;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic                r_err;

    logic [3:0]          w_hit;
    logic                w_any_hit;
    logic [1:0]          w_idx;
    logic [3:0]          w_cs_dec;
    logic                w_rd_lo;
    logic                w_wr_lo;
    logic                w_timeout;

    // Per-region address/space match
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_decode
            assign w_hit[gi] = (Address >= REG_LO[gi]) && (Address <= REG_HI[gi]) &&
                               (IOM == REG_IOM[gi]);
        end
    endgenerate

    // Priority encode: iterate high to low so the lowest matching index wins
    always_comb begin
        w_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_idx = 2'(i);
            end
        end
        w_any_hit = |w_hit;
        w_cs_dec  = w_any_hit ? (4'b0001 << w_idx) : 4'b0000;
    end

    assign w_rd_lo   = ~RD;
    assign w_wr_lo   = ~WR;
    assign w_timeout = (r_state != c_IDLE) && (r_tcnt == c_TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= c_IDLE;
            r_cs     <= 4'b0000;
            r_region <= 2'd0;
            r_wcnt   <= 3'd0;
            r_tcnt   <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (ALE) begin
                // A new ALE always starts a fresh cycle, abandoning any
                // cycle in progress without reporting an error.
                r_tcnt   <= '0;
                r_wcnt   <= 3'd0;
                r_cs     <= w_cs_dec;
                r_region <= w_idx;
                if (w_any_hit) begin
                    r_state <= c_ADDR;
                end else begin
                    r_state <= c_IDLE;
                    r_err   <= 1'b1;
                end
            end else if (w_timeout) begin
                r_state <= c_IDLE;
                r_cs    <= 4'b0000;
                r_wcnt  <= 3'd0;
                r_tcnt  <= '0;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_state <= c_IDLE;
                    end
                    c_ADDR: begin
                        r_tcnt <= r_tcnt + c_TCNT_W'(1);
                        if (w_rd_lo && w_wr_lo) begin
                            r_state <= c_IDLE;
                            r_cs    <= 4'b0000;
                            r_err   <= 1'b1;
                        end else if (w_rd_lo ^ w_wr_lo) begin
                            if (REG_WAIT[r_region] != 3'd0) begin
                                r_state <= c_WAIT;
                                r_wcnt  <= REG_WAIT[r_region];
                            end else begin
                                r_state <= c_XFER;
                            end
                        end
                    end
                    c_WAIT: begin
                        r_tcnt <= r_tcnt + c_TCNT_W'(1);
                        r_wcnt <= r_wcnt - 3'd1;
                        if (r_wcnt == 3'd1) begin
                            r_state <= c_XFER;
                        end
                    end
                    c_XFER: begin
                        r_tcnt <= r_tcnt + c_TCNT_W'(1);
                        if (RD && WR) begin
                            r_state <= c_IDLE;
                            r_cs    <= 4'b0000;
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                        r_cs    <= 4'b0000;
                    end
                endcase
            end
        end
    end

    // CS follows the live decode during ALE so the peripheral sees its select
    // in the same cycle it samples ALE.
    assign CS      = ALE ? w_cs_dec : r_cs;
    assign READY   = (r_state != c_WAIT);
    assign bus_err = r_err;
    assign region  = r_region;

endmodule
`default_nettype wire
